alu_matriz_param: RTL and testbench
===================================

# alu_matriz_param

Parametrised matrix ALU for the coprocessor datapath. It generalises the fixed 5x5/8-bit matrix ALU to DIM x DIM matrices of WIDTH-bit signed elements. It adds a registered operand capture, an iterative element-per-cycle multiplier, a sticky overflow flag and an illegal-opcode error flag. It sits between the instruction decoder/memory interface and the result write-back, using the same level start/done handshake.

## Interface
- DIM, 5: matrix order; legal values 2..8.
- WIDTH, 8: element width in bits, two's complement; legal values 4..16.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  level request; sampled only in IDLE.
- opcode  in  4  operation select.
- data_escalar  in  WIDTH  signed scalar for the scalar-multiply operation.
- matrizA, matrizB  in  DIM*DIM*WIDTH  operands. Element (i,j) occupies bits [(i*DIM+j)*WIDTH +: WIDTH], row-major, (0,0) at LSB.
- matriz_resultante  out  DIM*DIM*WIDTH  result, same layout.
- done  out  1  result valid; held until start falls.
- overflow  out  1  at least one element left the signed WIDTH range during the last operation.
- erro  out  1  last opcode was unsupported.

## Operation
- States: IDLE, CALC, MUL, DONE.
- IDLE with start=1:
  - Latch opcode, data_escalar, matrizA and matrizB into internal registers.
  - Clear overflow and erro.
  - Go to MUL if opcode=0101, otherwise go to CALC.
- Operand inputs may change freely after the capture edge.
- Opcodes:
  - 0011 soma: A+B.
  - 0100 subtracao: A−B.
  - 0101 multiplicacao: A×B.
  - 0110 transposta: Aᵀ.
  - 0111 oposta: −A.
  - 1000 escalar: data_escalar·A.
  - Any other opcode, including 1001–1100 (determinants, handled by a separate unit): no computation, erro=1, matriz_resultante unchanged.
- CALC, one cycle:
  - Write the full element-wise result into matriz_resultante.
  - Set done=1 and go to DONE.
- MUL:
  - Index counter k counts 0..DIM*DIM−1, with i=k/DIM and j=k%DIM.
  - Each cycle, compute the dot product of row i of A and column j of B in a 2*WIDTH+clog2(DIM)-bit signed accumulator and write it into element (i,j).
  - At k=DIM*DIM−1, set done=1 and go to DONE. The counter resets to 0.
  - Elements not yet written keep their previous values until overwritten.
- Arithmetic:
  - Every element is computed at full precision, then reduced to WIDTH bits.
  - overflow is set (sticky for the operation) if any full-precision element lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Reduction is wrap (truncation) unless saturation is compiled in. For example, −(−128) gives −128 at WIDTH=8.
- DONE:
  - Hold done=1 and all outputs while start=1.
  - When start=0, clear done and return to IDLE.
- Reset, asynchronous, at any time including mid-MUL: state=IDLE, k=0, matriz_resultante=0, done=0, overflow=0, erro=0.

## Timing
- Capture edge is edge 0, when start=1 is seen in IDLE.
- Element-wise ops and the illegal opcode: done=1 after edge 1, a latency of 1 cycle after capture.
- Multiplication: done=1 after edge DIM*DIM (25 cycles for DIM=5).
- done falls on the first edge at which start=0 in DONE. The earliest re-capture is the edge after that.
- Dropping start in CALC or MUL does not abort the operation. The result completes, done pulses high for exactly one cycle, then the block returns to IDLE.
- overflow and erro update on the same edge as done and stay stable until the next capture.

## Configuration
- ALU_SATURATE_EN defined: out-of-range elements clamp to 2^(WIDTH−1)−1 or −2^(WIDTH−1). overflow is still reported.
- ALU_SATURATE_EN undefined: elements wrap modulo 2^WIDTH.

## Test plan
- DIM=5, WIDTH=8, soma with A(all 3) and B(all 4): every element is 7, done high after 1 cycle, overflow=0, erro=0. Hold start for 10 cycles: done and result stay stable.
- multiplicacao with A=identity and B having element (i,j)=i*5+j: result equals B, done first high 25 cycles after capture, and at no earlier cycle.
- oposta with A(0,0)=−128 and the rest 0: without the macro, element (0,0)=−128 (0x80) and overflow=1. With ALU_SATURATE_EN, element (0,0)=127 and overflow=1.
- escalar with data_escalar=−2 and A(all 100): overflow=1. Wrap build gives 56 (−200 mod 256). Saturate build gives −128.
- opcode 1011 after a prior soma result of all 7: erro=1, done after 1 cycle, result still all 7.
- rst_n pulsed low at MUL cycle 10: done, overflow, erro and the result are 0 immediately. A new soma after reset completes normally.

Source files
------------

// File: rtl/alu_matriz_param.sv
// Parametrised DIM x DIM signed matrix ALU with a level start/done handshake.
// Optional build macro: ALU_SATURATE_EN (clamp out-of-range elements instead of wrapping).
module alu_matriz_param #(
    parameter int DIM   = 5,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               opcode,
    input  logic [WIDTH-1:0]         data_escalar,
    input  logic [DIM*DIM*WIDTH-1:0] matrizA,
    input  logic [DIM*DIM*WIDTH-1:0] matrizB,
    output logic [DIM*DIM*WIDTH-1:0] matriz_resultante,
    output logic                     done,
    output logic                     overflow,
    output logic                     erro
);
    localparam int N     = DIM * DIM;
    localparam int MAT_W = N * WIDTH;
    localparam int ACC_W = 2 * WIDTH + $clog2(DIM);
    localparam int K_W   = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_SOMA   = 4'b0011;
    localparam logic [3:0] OP_SUB    = 4'b0100;
    localparam logic [3:0] OP_MUL    = 4'b0101;
    localparam logic [3:0] OP_TRANSP = 4'b0110;
    localparam logic [3:0] OP_OPOSTA = 4'b0111;
    localparam logic [3:0] OP_ESC    = 4'b1000;

    localparam logic [K_W-1:0]          K_LAST = K_W'(N - 1);
    localparam logic signed [ACC_W-1:0] E_MAX  = ACC_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] E_MIN  = ~E_MAX;

    function automatic logic signed [ACC_W-1:0] sx(input logic [WIDTH-1:0] v);
        return ACC_W'($signed(v));
    endfunction

    function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
        return (v > E_MAX) || (v < E_MIN);
    endfunction

    function automatic logic [WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef ALU_SATURATE_EN
        if (v > E_MAX) return E_MAX[WIDTH-1:0];
        if (v < E_MIN) return E_MIN[WIDTH-1:0];
`endif
        return v[WIDTH-1:0];
    endfunction

    logic [1:0]       state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] esc_q, esc_d;
    logic [MAT_W-1:0] a_q, a_d, b_q, b_d;
    logic [MAT_W-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             erro_q, erro_d;
    logic             acc_ovf_q, acc_ovf_d;

    logic [MAT_W-1:0]          ew_res;
    logic                      ew_ovf, ew_legal;
    logic signed [ACC_W-1:0]   a_e, b_e, t_e, full;
    logic signed [ACC_W-1:0]   dot;
    int                        row, col;

    // Element-wise result for every element at once, evaluated at full precision.
    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        ew_res   = '0;
        ew_ovf   = 1'b0;
        ew_legal = 1'b1;
        a_e      = '0;
        b_e      = '0;
        t_e      = '0;
        full     = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                a_e = sx(a_q[(i*DIM+j)*WIDTH +: WIDTH]);
                b_e = sx(b_q[(i*DIM+j)*WIDTH +: WIDTH]);
                t_e = sx(a_q[(j*DIM+i)*WIDTH +: WIDTH]);
                case (op_q)
                    OP_SOMA:   full = a_e + b_e;
                    OP_SUB:    full = a_e - b_e;
                    OP_TRANSP: full = t_e;
                    OP_OPOSTA: full = -a_e;
                    OP_ESC:    full = sx(esc_q) * a_e;
                    default: begin
                        full     = '0;
                        ew_legal = 1'b0;
                    end
                endcase
                ew_ovf = ew_ovf | out_of_range(full);
                ew_res[(i*DIM+j)*WIDTH +: WIDTH] = reduce(full);
            end
        end
    end

    // Dot product of row k/DIM of A with column k%DIM of B.
    always_comb begin
        row = int'(k_q) / DIM;
        col = int'(k_q) % DIM;
        dot = '0;
        for (int t = 0; t < DIM; t++) begin
            dot = dot + sx(a_q[(row*DIM+t)*WIDTH +: WIDTH]) * sx(b_q[(t*DIM+col)*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        op_d      = op_q;
        esc_d     = esc_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        erro_d    = erro_q;
        acc_ovf_d = acc_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = opcode;
                    esc_d     = data_escalar;
                    a_d       = matrizA;
                    b_d       = matrizB;
                    ovf_d     = 1'b0;
                    erro_d    = 1'b0;
                    acc_ovf_d = 1'b0;
                    k_d       = '0;
                    state_d   = (opcode == OP_MUL) ? S_MUL : S_CALC;
                end
            end
            S_CALC: begin
                if (ew_legal) begin
                    res_d = ew_res;
                    ovf_d = ew_ovf;
                end else begin
                    erro_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_MUL: begin
                res_d[int'(k_q)*WIDTH +: WIDTH] = reduce(dot);
                // overflow is published only with done; the running flag lives in acc_ovf.
                if (k_q == K_LAST) begin
                    ovf_d   = acc_ovf_q | out_of_range(dot);
                    done_d  = 1'b1;
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    acc_ovf_d = acc_ovf_q | out_of_range(dot);
                    k_d       = k_q + K_W'(1);
                end
            end
            S_DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: operand registers carry no reset; they are always loaded at capture before use.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        esc_q <= esc_d;
        a_q   <= a_d;
        b_q   <= b_d;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            erro_q    <= 1'b0;
            acc_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            res_q     <= res_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            erro_q    <= erro_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

    assign matriz_resultante = res_q;
    assign done              = done_q;
    assign overflow          = ovf_q;
    assign erro              = erro_q;

endmodule

// File: tb/tb_alu_matriz_param.sv
// Self-checking bench for alu_matriz_param (DIM=5, WIDTH=8) against an integer matrix model.
// Honours ALU_SATURATE_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_matriz_param;
    localparam int DIM   = 5;
    localparam int WIDTH = 8;
    localparam int N     = DIM * DIM;
    localparam int MW    = N * WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    opcode;
    logic [7:0]    data_escalar;
    logic [MW-1:0] matrizA, matrizB, matriz_resultante;
    logic          done, overflow, erro;

    int n_checks = 0;
    int n_pass   = 0;

    int            ma[N], mb[N], mr[N];
    bit            m_ovf, m_err;
    logic [MW-1:0] exp_vec;

    alu_matriz_param #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .opcode            (opcode),
        .data_escalar      (data_escalar),
        .matrizA           (matrizA),
        .matrizB           (matrizB),
        .matriz_resultante (matriz_resultante),
        .done              (done),
        .overflow          (overflow),
        .erro              (erro)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reduce a full-precision integer to an 8-bit signed element value.
    function automatic int fit(input int x);
`ifdef ALU_SATURATE_EN
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
`else
        int m;
        m = x & 255;
        return (m > 127) ? m - 256 : m;
`endif
    endfunction

    task automatic model_apply(input int op, input int esc);
        int full;
        m_ovf = 0;
        m_err = 0;
        if (!(op inside {3, 4, 5, 6, 7, 8})) begin
            m_err = 1;
            return;
        end
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                case (op)
                    3: full = ma[i*DIM+j] + mb[i*DIM+j];
                    4: full = ma[i*DIM+j] - mb[i*DIM+j];
                    5: begin
                        full = 0;
                        for (int t = 0; t < DIM; t++) full += ma[i*DIM+t] * mb[t*DIM+j];
                    end
                    6: full = ma[j*DIM+i];
                    7: full = -ma[i*DIM+j];
                    default: full = esc * ma[i*DIM+j];
                endcase
                if (full > 127 || full < -128) m_ovf = 1;
                mr[i*DIM+j] = fit(full);
            end
        end
    endtask

    task automatic build_exp();
        for (int k = 0; k < N; k++) exp_vec[k*WIDTH +: WIDTH] = 8'(mr[k]);
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < N; k++) begin
            matrizA[k*WIDTH +: WIDTH] = 8'($urandom);
            matrizB[k*WIDTH +: WIDTH] = 8'($urandom);
        end
        opcode       = 4'($urandom);
        data_escalar = 8'($urandom);
    endtask

    // Capture an operation, then scramble the inputs and count edges until done (-1 on timeout).
    task automatic run_op(input int op, input int esc, output int lat);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            matrizA[k*WIDTH +: WIDTH] = 8'(ma[k]);
            matrizB[k*WIDTH +: WIDTH] = 8'(mb[k]);
        end
        opcode       = op[3:0];
        data_escalar = 8'(esc);
        start        = 1'b1;
        @(posedge clk);
        #1;
        scramble_inputs();
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        model_apply(op, esc);
        build_exp();
    endtask

    task automatic end_op(output logic d);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        d = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        opcode = '0;
        data_escalar = '0;
        matrizA = '0;
        matrizB = '0;
        for (int k = 0; k < N; k++) mr[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        n_checks++; if (erro !== 1'b0) $display("FAIL reset_erro: got %b expected 0", erro); else n_pass++;
        n_checks++; if (matriz_resultante !== '0) $display("FAIL reset_result: got %h expected 0", matriz_resultante); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_soma_hold();
        int   lat;
        logic d;
        for (int k = 0; k < N; k++) begin ma[k] = 3; mb[k] = 4; end
        run_op(3, 0, lat);
        n_checks++; if (lat !== 1) $display("FAIL soma_latency: got %0d expected 1", lat); else n_pass++;
        n_checks++; if (matriz_resultante !== exp_vec) $display("FAIL soma_result: got %h expected %h", matriz_resultante, exp_vec); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || erro !== 1'b0) $display("FAIL soma_flags: got ovf=%b erro=%b expected 0 0", overflow, erro); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b1 || matriz_resultante !== exp_vec)
                $display("FAIL soma_hold cycle %0d: got done=%b result=%h expected done=1 result=%h", c, done, matriz_resultante, exp_vec);
            else n_pass++;
        end
        end_op(d);
        n_checks++; if (d !== 1'b0) $display("FAIL soma_done_fall: got %b expected 0", d); else n_pass++;
    endtask

    task automatic test_mul_identity();
        int   lat;
        logic d;
        for (int k = 0; k < N; k++) begin
            ma[k] = ((k / DIM) == (k % DIM)) ? 1 : 0;
            mb[k] = k;
        end
        run_op(5, 0, lat);
        n_checks++; if (lat !== 25) $display("FAIL mul_latency: got %0d expected 25", lat); else n_pass++;
        n_checks++; if (matriz_resultante !== exp_vec) $display("FAIL mul_result: got %h expected %h", matriz_resultante, exp_vec); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || erro !== 1'b0) $display("FAIL mul_flags: got ovf=%b erro=%b expected 0 0", overflow, erro); else n_pass++;
        end_op(d);
    endtask

    task automatic test_oposta_min();
        int   lat;
        logic d;
        for (int k = 0; k < N; k++) ma[k] = 0;
        ma[0] = -128;
        run_op(7, 0, lat);
        n_checks++; if (lat !== 1) $display("FAIL oposta_latency: got %0d expected 1", lat); else n_pass++;
        n_checks++; if (matriz_resultante !== exp_vec) $display("FAIL oposta_result: got %h expected %h", matriz_resultante, exp_vec); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL oposta_overflow: got %b expected 1", overflow); else n_pass++;
        end_op(d);
    endtask

    task automatic test_escalar();
        int   lat;
        logic d;
        for (int k = 0; k < N; k++) ma[k] = 100;
        run_op(8, -2, lat);
        n_checks++; if (lat !== 1) $display("FAIL escalar_latency: got %0d expected 1", lat); else n_pass++;
        n_checks++; if (matriz_resultante !== exp_vec) $display("FAIL escalar_result: got %h expected %h", matriz_resultante, exp_vec); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL escalar_overflow: got %b expected 1", overflow); else n_pass++;
        end_op(d);
    endtask

    task automatic test_illegal_opcode();
        int   lat;
        logic d;
        for (int k = 0; k < N; k++) begin ma[k] = 3; mb[k] = 4; end
        run_op(3, 0, lat);
        end_op(d);
        run_op(11, 0, lat);
        n_checks++; if (lat !== 1) $display("FAIL illegal_latency: got %0d expected 1", lat); else n_pass++;
        n_checks++; if (erro !== 1'b1) $display("FAIL illegal_erro: got %b expected 1", erro); else n_pass++;
        n_checks++; if (matriz_resultante !== exp_vec) $display("FAIL illegal_result_kept: got %h expected %h", matriz_resultante, exp_vec); else n_pass++;
        end_op(d);
    endtask

    task automatic test_random_ops();
        int   ops[9] = '{3, 4, 5, 6, 7, 8, 0, 11, 15};
        int   op, esc, lat, exp_lat;
        logic d;
        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < N; k++) begin
                ma[k] = int'($urandom_range(0, 255)) - 128;
                mb[k] = int'($urandom_range(0, 255)) - 128;
            end
            op      = ops[$urandom_range(0, 8)];
            esc     = int'($urandom_range(0, 255)) - 128;
            exp_lat = (op == 5) ? 25 : 1;
            run_op(op, esc, lat);
            n_checks++;
            if (lat !== exp_lat || matriz_resultante !== exp_vec || overflow !== m_ovf || erro !== m_err)
                $display("FAIL random op=%0d: got lat=%0d ovf=%b erro=%b res=%h expected lat=%0d ovf=%b erro=%b res=%h",
                         op, lat, overflow, erro, matriz_resultante, exp_lat, m_ovf, m_err, exp_vec);
            else n_pass++;
            end_op(d);
            n_checks++; if (d !== 1'b0) $display("FAIL random_done_fall op=%0d: got %b expected 0", op, d); else n_pass++;
        end
    endtask

    task automatic test_drop_start();
        int lat;
        for (int k = 0; k < N; k++) begin
            ma[k] = int'($urandom_range(0, 255)) - 128;
            mb[k] = int'($urandom_range(0, 255)) - 128;
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            matrizA[k*WIDTH +: WIDTH] = 8'(ma[k]);
            matrizB[k*WIDTH +: WIDTH] = 8'(mb[k]);
        end
        opcode = 4'b0101;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        model_apply(5, 0);
        build_exp();
        n_checks++; if (lat !== 25) $display("FAIL drop_start_latency: got %0d expected 25", lat); else n_pass++;
        n_checks++; if (matriz_resultante !== exp_vec || overflow !== m_ovf) $display("FAIL drop_start_result: got ovf=%b %h expected ovf=%b %h", overflow, matriz_resultante, m_ovf, exp_vec); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) $display("FAIL drop_start_pulse: got done=%b expected 0", done); else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        int   lat;
        logic d;
        for (int k = 0; k < N; k++) begin
            ma[k] = int'($urandom_range(1, 100));
            mb[k] = int'($urandom_range(1, 100));
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            matrizA[k*WIDTH +: WIDTH] = 8'(ma[k]);
            matrizB[k*WIDTH +: WIDTH] = 8'(mb[k]);
        end
        opcode = 4'b0101;
        start  = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || overflow !== 1'b0 || erro !== 1'b0 || matriz_resultante !== '0)
            $display("FAIL reset_mid_mul: got done=%b ovf=%b erro=%b res=%h expected all 0", done, overflow, erro, matriz_resultante);
        else n_pass++;
        for (int k = 0; k < N; k++) mr[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin ma[k] = 3; mb[k] = 4; end
        run_op(3, 0, lat);
        n_checks++; if (lat !== 1) $display("FAIL post_reset_latency: got %0d expected 1", lat); else n_pass++;
        n_checks++; if (matriz_resultante !== exp_vec) $display("FAIL post_reset_result: got %h expected %h", matriz_resultante, exp_vec); else n_pass++;
        end_op(d);
    endtask

    initial begin
        test_reset();
        test_soma_hold();
        test_mul_identity();
        test_oposta_min();
        test_escalar();
        test_illegal_opcode();
        test_random_ops();
        test_drop_start();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
